// File: rtl/mem_initiator.sv
// Single-port-per-side memory initiator: arbitrates fetch vs load/store requests into one-cycle
// memory accesses. Optional macro MEM_ALIGN_CHECK_EN also rejects addresses with bits [1:0] != 0.
module mem_initiator #(
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic        mem_Clk,
    input  logic        Reset_n,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    output logic        fetch_ack,
    output logic [31:0] fetch_instr,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,
    output logic        err,
    output logic        instruction_memory_en,
    output logic [31:0] instruction_memory_a,
    input  logic [31:0] instruction_memory_v,
    output logic [31:0] data_memory_a,
    output logic        data_memory_read,
    output logic        data_memory_write,
    output logic [31:0] data_memory_out_v,
    input  logic [31:0] data_memory_in_v
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Last byte address at which a full 32-bit word still fits; compared directly, never as addr+3.
    localparam logic [31:0] ADDR_LAST = 32'(MEM_BYTES - 32'd4);

    function automatic logic addr_reject(input logic [31:0] addr);
        logic bad;
        bad = (addr > ADDR_LAST);
`ifdef MEM_ALIGN_CHECK_EN
        bad = bad | (addr[1:0] != 2'b00);
`else
        bad = bad | 1'b0;
`endif
        return bad;
    endfunction

    state_t      state_q, state_d;
    logic        imem_en_q, imem_en_d;
    logic [31:0] imem_a_q, imem_a_d;
    logic [31:0] dmem_a_q, dmem_a_d;
    logic        dmem_rd_q, dmem_rd_d;
    logic        dmem_wr_q, dmem_wr_d;
    logic [31:0] dmem_out_q, dmem_out_d;
    logic        fetch_ack_q, fetch_ack_d;
    logic        ls_ack_q, ls_ack_d;
    logic        err_q, err_d;
    logic [31:0] fetch_instr_q, fetch_instr_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    // Next-state and registered-output decode; strobes default low so each lasts exactly one cycle.
    always_comb begin
        state_d       = state_q;
        imem_a_d      = imem_a_q;
        dmem_a_d      = dmem_a_q;
        dmem_out_d    = dmem_out_q;
        fetch_instr_d = fetch_instr_q;
        ls_rdata_d    = ls_rdata_q;
        imem_en_d     = 1'b0;
        dmem_rd_d     = 1'b0;
        dmem_wr_d     = 1'b0;
        fetch_ack_d   = 1'b0;
        ls_ack_d      = 1'b0;
        err_d         = 1'b0;
        case (state_q)
            IDLE: begin
                if (ls_req) begin
                    dmem_a_d   = ls_addr;
                    dmem_out_d = ls_wdata;
                    if (addr_reject(ls_addr)) begin
                        state_d  = DONE;
                        ls_ack_d = 1'b1;
                        err_d    = 1'b1;
                    end else if (ls_we) begin
                        state_d   = STORE;
                        dmem_wr_d = 1'b1;
                    end else begin
                        state_d   = LOAD;
                        dmem_rd_d = 1'b1;
                    end
                end else if (fetch_req) begin
                    imem_a_d = fetch_pc;
                    if (addr_reject(fetch_pc)) begin
                        state_d     = DONE;
                        fetch_ack_d = 1'b1;
                        err_d       = 1'b1;
                    end else begin
                        state_d   = FETCH;
                        imem_en_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                fetch_instr_d = instruction_memory_v;
                fetch_ack_d   = 1'b1;
                state_d       = DONE;
            end
            LOAD: begin
                ls_rdata_d = data_memory_in_v;
                ls_ack_d   = 1'b1;
                state_d    = DONE;
            end
            // Load data is undefined while writing, so ls_rdata is deliberately left alone.
            STORE: begin
                ls_ack_d = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight without an ack.
    always_ff @(posedge mem_Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            imem_en_q     <= 1'b0;
            imem_a_q      <= 32'd0;
            dmem_a_q      <= 32'd0;
            dmem_rd_q     <= 1'b0;
            dmem_wr_q     <= 1'b0;
            dmem_out_q    <= 32'd0;
            fetch_ack_q   <= 1'b0;
            ls_ack_q      <= 1'b0;
            err_q         <= 1'b0;
            fetch_instr_q <= 32'd0;
            ls_rdata_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            imem_en_q     <= imem_en_d;
            imem_a_q      <= imem_a_d;
            dmem_a_q      <= dmem_a_d;
            dmem_rd_q     <= dmem_rd_d;
            dmem_wr_q     <= dmem_wr_d;
            dmem_out_q    <= dmem_out_d;
            fetch_ack_q   <= fetch_ack_d;
            ls_ack_q      <= ls_ack_d;
            err_q         <= err_d;
            fetch_instr_q <= fetch_instr_d;
            ls_rdata_q    <= ls_rdata_d;
        end
    end

    assign fetch_ack             = fetch_ack_q;
    assign fetch_instr           = fetch_instr_q;
    assign ls_ack                = ls_ack_q;
    assign ls_rdata              = ls_rdata_q;
    assign err                   = err_q;
    assign instruction_memory_en = imem_en_q;
    assign instruction_memory_a  = imem_a_q;
    assign data_memory_a         = dmem_a_q;
    assign data_memory_read      = dmem_rd_q;
    assign data_memory_write     = dmem_wr_q;
    assign data_memory_out_v     = dmem_out_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator with a byte-addressed big-endian memory model.
// Expectations for the unaligned load follow MEM_ALIGN_CHECK_EN.
module tb_mem_initiator;

    logic        mem_Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_pc = 32'd0;
    logic        fetch_ack;
    logic [31:0] fetch_instr;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = 32'd0;
    logic [31:0] ls_wdata = 32'd0;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic        err;
    logic        instruction_memory_en;
    logic [31:0] instruction_memory_a;
    logic [31:0] instruction_memory_v;
    logic [31:0] data_memory_a;
    logic        data_memory_read;
    logic        data_memory_write;
    logic [31:0] data_memory_out_v;
    logic [31:0] data_memory_in_v;

    mem_initiator #(.MEM_BYTES(65536)) dut (
        .mem_Clk(mem_Clk), .Reset_n(Reset_n),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ack(fetch_ack), .fetch_instr(fetch_instr),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata), .err(err),
        .instruction_memory_en(instruction_memory_en), .instruction_memory_a(instruction_memory_a),
        .instruction_memory_v(instruction_memory_v),
        .data_memory_a(data_memory_a), .data_memory_read(data_memory_read),
        .data_memory_write(data_memory_write), .data_memory_out_v(data_memory_out_v),
        .data_memory_in_v(data_memory_in_v)
    );

    always #5 mem_Clk = ~mem_Clk;

    bit [7:0] mem [0:65535];
    bit       init_done = 1'b0;
    int       fetch_cyc = 0;
    int       rd_cyc = 0;
    int       wr_cyc = 0;
    int       both_cyc = 0;
    int       checks = 0;
    int       failures = 0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [15:0] b;
        b = a[15:0];
        return {mem[b], mem[b + 16'd1], mem[b + 16'd2], mem[b + 16'd3]};
    endfunction

    // Memory model: preload once, then commit writes and count access cycles.
    always @(posedge mem_Clk) begin
        if (!init_done) begin
            mem[16'h0010] <= 8'h12; mem[16'h0011] <= 8'h34;
            mem[16'h0012] <= 8'h56; mem[16'h0013] <= 8'h78;
            mem[16'h0104] <= 8'hCA; mem[16'h0105] <= 8'hFE;
            mem[16'hFFFC] <= 8'hA5; mem[16'hFFFD] <= 8'h5A;
            mem[16'hFFFE] <= 8'h0F; mem[16'hFFFF] <= 8'hF0;
            init_done <= 1'b1;
        end else if (data_memory_write) begin
            mem[data_memory_a[15:0]]          <= data_memory_out_v[31:24];
            mem[data_memory_a[15:0] + 16'd1]  <= data_memory_out_v[23:16];
            mem[data_memory_a[15:0] + 16'd2]  <= data_memory_out_v[15:8];
            mem[data_memory_a[15:0] + 16'd3]  <= data_memory_out_v[7:0];
        end
        if (instruction_memory_en) fetch_cyc <= fetch_cyc + 1;
        if (data_memory_read)      rd_cyc    <= rd_cyc + 1;
        if (data_memory_write)     wr_cyc    <= wr_cyc + 1;
        if (data_memory_read && data_memory_write) both_cyc <= both_cyc + 1;
    end

    // Memory read data presented mid-cycle so it is stable at the capturing edge.
    always @(negedge mem_Clk) begin
        instruction_memory_v <= rd_word(instruction_memory_a);
        data_memory_in_v     <= rd_word(data_memory_a);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] outs_or();
        return 32'(|{fetch_ack, fetch_instr, ls_ack, ls_rdata, err, instruction_memory_en,
                     instruction_memory_a, data_memory_a, data_memory_read, data_memory_write,
                     data_memory_out_v});
    endfunction

    task automatic run_txn(input bit is_ls, input bit we, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat, output bit got_err,
                           output logic [31:0] got_data, output bit stray, output bit fell);
        @(negedge mem_Clk);
        if (is_ls) begin
            ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wd;
        end else begin
            fetch_req = 1'b1; fetch_pc = addr;
        end
        lat = 0; stray = 1'b0; fell = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge mem_Clk);
            if (is_ls ? fetch_ack : ls_ack) stray = 1'b1;
            if (is_ls ? ls_ack : fetch_ack) begin
                lat = i;
                break;
            end
        end
        got_err  = err;
        got_data = is_ls ? ls_rdata : fetch_instr;
        ls_req = 1'b0; fetch_req = 1'b0;
        @(negedge mem_Clk);
        fell = !fetch_ack && !ls_ack && !err;
    endtask

    typedef struct {
        bit          is_ls;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        bit          exp_err;
        int          exp_lat;
        int          exp_f;
        int          exp_r;
        int          exp_w;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int lat, f0, r0, w0, n;
        bit gerr, stray, fell, seen;
        logic [31:0] gdata;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0, 2, 1, 0, 0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2, 0, 0, 1};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0, 1, 0};
        vecs[3] = '{1'b1, 1'b0, 32'h0001_0000, 32'h0,         32'hDEAD_BEEF, 1'b1, 1, 0, 0, 0};
        vecs[4] = '{1'b1, 1'b1, 32'h0001_0000, 32'h0000_0055, 32'hDEAD_BEEF, 1'b1, 1, 0, 0, 0};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_FFFC, 32'h0,         32'hA55A_0FF0, 1'b0, 2, 1, 0, 0};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_FFFD, 32'h0,         32'hA55A_0FF0, 1'b1, 1, 0, 0, 0};
        vecs[7] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'hA55A_0FF0, 1'b1, 1, 0, 0, 0};
        vecs[8] = '{1'b1, 1'b0, 32'h0000_FFFC, 32'h0,         32'hA55A_0FF0, 1'b0, 2, 0, 1, 0};
`ifdef MEM_ALIGN_CHECK_EN
        vecs[9] = '{1'b1, 1'b0, 32'h0000_0102, 32'h0,         32'hA55A_0FF0, 1'b1, 1, 0, 0, 0};
`else
        vecs[9] = '{1'b1, 1'b0, 32'h0000_0102, 32'h0,         32'hBEEF_CAFE, 1'b0, 2, 0, 1, 0};
`endif

        // Reset state, held across edges and after release.
        repeat (3) @(negedge mem_Clk);
        check("reset_outputs_zero", outs_or(), 32'd0);
        Reset_n = 1'b1;
        repeat (2) @(negedge mem_Clk);
        check("idle_after_reset", outs_or(), 32'd0);

        for (int v = 0; v < 10; v++) begin
            f0 = fetch_cyc; r0 = rd_cyc; w0 = wr_cyc;
            run_txn(vecs[v].is_ls, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                    lat, gerr, gdata, stray, fell);
            check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            check($sformatf("v%0d_err", v), 32'(gerr), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_data", v), gdata, vecs[v].exp_data);
            check($sformatf("v%0d_stray_ack", v), 32'(stray), 32'd0);
            check($sformatf("v%0d_ack_falls", v), 32'(fell), 32'd1);
            check($sformatf("v%0d_fetch_cycles", v), 32'(fetch_cyc - f0), 32'(vecs[v].exp_f));
            check($sformatf("v%0d_read_cycles", v), 32'(rd_cyc - r0), 32'(vecs[v].exp_r));
            check($sformatf("v%0d_write_cycles", v), 32'(wr_cyc - w0), 32'(vecs[v].exp_w));
        end
        check("mem_after_store", rd_word(32'h100), 32'hDEAD_BEEF);

        // Simultaneous requests: load/store wins, fetch follows three edges after its ack.
        @(negedge mem_Clk);
        fetch_req = 1'b1; fetch_pc = 32'h10;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100;
        n = 0; seen = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge mem_Clk);
            if (fetch_ack) seen = 1'b1;
            if (ls_ack) begin n = i; break; end
        end
        check("both_ls_latency", 32'(n), 32'd2);
        check("both_no_early_fetch_ack", 32'(seen), 32'd0);
        check("both_ls_rdata", ls_rdata, 32'hDEAD_BEEF);
        ls_req = 1'b0;
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge mem_Clk);
            if (fetch_ack) begin n = i; break; end
        end
        check("both_fetch_delay", 32'(n), 32'd3);
        check("both_fetch_instr", fetch_instr, 32'h1234_5678);
        fetch_req = 1'b0;
        repeat (2) @(negedge mem_Clk);

        // Reset pulse in the middle of a store cycle.
        w0 = wr_cyc;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h1122_3344;
        @(posedge mem_Clk);
        #1;
        check("store_write_high", 32'(data_memory_write), 32'd1);
        check("store_addr", data_memory_a, 32'h200);
        #2;
        Reset_n = 1'b0;
        #1;
        check("reset_mid_store_outputs", outs_or(), 32'd0);
        ls_req = 1'b0;
        repeat (2) @(negedge mem_Clk);
        Reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge mem_Clk);
            if (fetch_ack || ls_ack || err || data_memory_write) seen = 1'b1;
        end
        check("no_ack_after_abort", 32'(seen), 32'd0);
        check("aborted_write_count", 32'(wr_cyc - w0), 32'd0);
        check("aborted_mem_word", rd_word(32'h200), 32'd0);
        check("post_reset_outputs", outs_or(), 32'd0);
        check("read_write_overlap", 32'(both_cyc), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 Parameter MEM_BYTES, default 65536, byte size of the unified instruction/data memory; addresses above MEM_BYTES-4 are out of range.
REQ-002 mem_Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Reset_n  input  1  asynchronous, active-low reset.
REQ-004 fetch_req  input  1  fetch request; held high until fetch_ack.
REQ-005 fetch_pc  input  32  fetch byte address.
REQ-006 fetch_ack  output  1  one-cycle pulse; fetch_instr valid.
REQ-007 fetch_instr  output  32  fetched instruction word, big-endian.
REQ-008 ls_req  input  1  load/store request; held high until ls_ack.
REQ-009 ls_we  input  1  1 = store, 0 = load.
REQ-010 ls_addr  input  32  load/store byte address.
REQ-011 ls_wdata  input  32  store data.
REQ-012 ls_ack  output  1  one-cycle pulse; ls_rdata valid for loads.
REQ-013 ls_rdata  output  32  load result.
REQ-014 err  output  1  one-cycle pulse with the ack of a rejected request.
REQ-015 instruction_memory_en, instruction_memory_a[31:0]  outputs  fetch port to memory.
REQ-016 instruction_memory_v  input  32  memory fetch data.
REQ-017 data_memory_a[31:0], data_memory_read, data_memory_write, data_memory_out_v[31:0]  outputs  data port to memory.
REQ-018 data_memory_in_v  input  32  memory load data.

Function
REQ-019 FSM states: IDLE, FETCH, LOAD, STORE, DONE.
REQ-020 In IDLE, on a rising edge with ls_req high: latch ls_addr, ls_wdata and ls_we, then go to STORE if ls_we is 1, else LOAD; ls_req takes priority over fetch_req.
REQ-021 In IDLE, with ls_req low and fetch_req high: latch fetch_pc and go to FETCH.
REQ-022 FETCH: instruction_memory_en=1 and instruction_memory_a=latched address for exactly one cycle; capture instruction_memory_v into fetch_instr at the closing edge.
REQ-023 LOAD: data_memory_read=1, data_memory_a=latched address for one cycle; capture data_memory_in_v into ls_rdata at the closing edge.
REQ-024 STORE: data_memory_write=1 with data_memory_a and data_memory_out_v latched for one cycle; ls_rdata is not updated (memory load data is undefined during a write).
REQ-025 DONE: pulse the matching ack (and err if rejected) for one cycle, then return to IDLE; latency is 3 edges from the accepting edge to the ack falling.
REQ-026 Outside FETCH, instruction_memory_en=0; outside LOAD/STORE, data_memory_read=0 and data_memory_write=0; read and write are never high together.
REQ-027 An out-of-range address skips the memory cycle (goes straight to DONE) and raises err with the ack; fetch_instr and ls_rdata stay unchanged.
REQ-028 A request dropped before its ack is still completed; the next request is accepted only from IDLE.
REQ-029 Address arithmetic is unsigned 32-bit; the range check compares against MEM_BYTES-4 without wrap-around.

Reset
REQ-030 Reset_n low asynchronously forces IDLE and clears all enables, acks, err, fetch_instr, ls_rdata and all latched registers to 0.
REQ-031 A reset during FETCH/LOAD/STORE aborts the access with no ack; a write cycle already cut off by reset is not retried.

Configuration
REQ-032 Macro MEM_ALIGN_CHECK_EN: when defined, any address with bits [1:0] not equal to 0 is rejected as in REQ-027; when undefined, unaligned addresses are passed through unchanged.

Verification
REQ-033 Fetch at 0x0000_0010 with memory bytes 12 34 56 78 -> fetch_instr=0x12345678, fetch_ack on the 3rd edge.
REQ-034 Store 0xDEADBEEF to 0x100, then load 0x100 -> one write cycle, then ls_rdata=0xDEADBEEF, err=0.
REQ-035 fetch_req and ls_req rise together -> load/store serviced first, fetch acked 3 edges later.
REQ-036 Load from 0x0001_0000 (MEM_BYTES=65536) -> no data_memory_read, ls_ack with err=1.
REQ-037 Load from 0x102 -> err=1 with MEM_ALIGN_CHECK_EN defined; bytes 0x102..0x105 returned without it.
REQ-038 Reset_n pulsed low during STORE -> all outputs 0 immediately, no ack, FSM in IDLE.
